// File: rtl/sample_ingest.sv
// sample_ingest
//   Input acquisition stage ahead of the wavelet filter core. The external
//   strobe i_data_clk is asynchronous to clk. This block:
//   - synchronises i_data_clk into the clk domain;
//   - captures i_value on each rising edge of the synchronised strobe;
//   - buffers captured samples in a small FIFO;
//   - re-issues them as single-cycle o_data_strobe pulses spaced exactly
//     MIN_GAP cycles apart while data is waiting.
//   Samples that arrive when the FIFO is full are dropped, and the drop is
//   latched in o_overflow until it is cleared.
//
// Ports
//   clk              system clock
//   rst              asynchronous reset, active low
//   i_value          signed external sample
//   i_data_clk       asynchronous sample strobe; sample taken on its rise
//   i_clear_overflow synchronous clear of o_overflow (a drop in the same
//                    cycle takes priority)
//   o_value          sample presented to the shift line (held between pops)
//   o_data_strobe    one-cycle pulse; o_value is valid in the same cycle
//   o_fifo_level     current FIFO occupancy
//   o_overflow       sticky dropped-sample flag
module sample_ingest #(
  parameter int BITS_PER_ELEM = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int MIN_GAP       = 16,
  parameter int LEVEL_BITS    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [BITS_PER_ELEM-1:0] i_value,
  input  logic                            i_data_clk,
  input  logic                            i_clear_overflow,
  output logic signed [BITS_PER_ELEM-1:0] o_value,
  output logic                            o_data_strobe,
  output logic [LEVEL_BITS-1:0]           o_fifo_level,
  output logic                            o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int GAP_W = $clog2(MIN_GAP);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [LEVEL_BITS-1:0] FULL = LEVEL_BITS'(FIFO_DEPTH);

  typedef enum logic {IDLE, GAP} state_t;

  // ---------------------------------------------------------------------
  // Strobe synchroniser and rising-edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_last;
  logic                   prev;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   rise;

  assign sync_last = sync_pipe[SYNC_STAGES-1];

  // While the chain refills after reset, prev keeps following it, but
  // rise stays masked. A strobe that is already high when reset is
  // released therefore never looks like a new edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
      arm_cnt   <= '0;
      armed     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], i_data_clk};
      prev      <= sync_last;
      if (!armed) begin
        if (arm_cnt == ARM_W'(SYNC_STAGES)) armed <= 1'b1;
        else                                arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  assign rise = sync_last & ~prev & armed;

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic [BITS_PER_ELEM-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     pop;
  logic                     push;
  logic                     drop;
  state_t                   state;
  logic [GAP_W-1:0]         gap_cnt;

  assign pop = (state == IDLE) && (o_fifo_level != '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // still accepted in that case.
  assign push = rise && ((o_fifo_level != FULL) || pop);
  assign drop = rise && (o_fifo_level == FULL) && !pop;

  // The sample storage needs no reset; only the pointers and the level
  // decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_value;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_fifo_level <= o_fifo_level + 1'b1;
        2'b01:   o_fifo_level <= o_fifo_level - 1'b1;
        default: o_fifo_level <= o_fifo_level;
      endcase
      if (drop)                  o_overflow <= 1'b1;
      else if (i_clear_overflow) o_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Issue FSM: pop in IDLE, then hold off in GAP for MIN_GAP-1 cycles.
  // Leaving GAP as the counter reaches zero lets IDLE pop again on the
  // next edge. Back-to-back strobes are then exactly MIN_GAP cycles apart.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      o_value       <= '0;
      o_data_strobe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_data_strobe <= 1'b0;
          if (pop) begin
            o_value       <= mem[rd_ptr];
            o_data_strobe <= 1'b1;
            gap_cnt       <= GAP_W'(MIN_GAP - 1);
            state         <= GAP;
          end
        end
        GAP: begin
          o_data_strobe <= 1'b0;
          gap_cnt       <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
        end
        default: begin
          o_data_strobe <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_ingest.sv
// tb_sample_ingest
//   Directed bench for sample_ingest. It uses the default parameters.
//   A free-running edge counter (cyc) numbers the clk edges. A negedge
//   monitor records the edge number and value of every o_data_strobe.
//   The main sequence then compares those records with latencies worked
//   out by hand. Inputs change 1 ns after a rising edge, so a strobe
//   driven high there is first sampled at the next edge.
module tb_sample_ingest;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_value = '0;
  logic       i_data_clk = 1'b0;
  logic       i_clear_overflow = 1'b0;
  logic [7:0] o_value;
  logic       o_data_strobe;
  logic [2:0] o_fifo_level;
  logic       o_overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int peak = 0;
  int sc[$];
  int sv[$];

  sample_ingest dut (
    .clk              (clk),
    .rst              (rst),
    .i_value          (i_value),
    .i_data_clk       (i_data_clk),
    .i_clear_overflow (i_clear_overflow),
    .o_value          (o_value),
    .o_data_strobe    (o_data_strobe),
    .o_fifo_level     (o_fifo_level),
    .o_overflow       (o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_data_strobe === 1'b1) begin
      sc.push_back(cyc);
      sv.push_back(int'(o_value));
    end
    if (int'(o_fifo_level) > peak) peak = int'(o_fifo_level);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Drives i_data_clk so that it is first sampled high at edge e0.
  // It stays high for two edges, and i_value stays stable until after
  // the edge that captures it (e0+2).
  task automatic pulse_at(input int e0, input logic [7:0] v);
    wait_until(e0 - 1);
    i_value    = v;
    i_data_clk = 1'b1;
    wait_until(e0 + 1);
    i_data_clk = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gc(input int i);
    return (i < sc.size()) ? sc[i] : -1;
  endfunction

  function automatic int gv(input int i);
    return (i < sv.size()) ? sv[i] : -1;
  endfunction

  initial begin
    int b;
    int c;
    int r;

    // Reset state
    #2 rst = 1'b0;
    repeat (3) step();
    chk("rst_value",    int'(o_value), 0);
    chk("rst_strobe",   int'(o_data_strobe), 0);
    chk("rst_level",    int'(o_fifo_level), 0);
    chk("rst_overflow", int'(o_overflow), 0);
    rst = 1'b1;
    repeat (8) step();

    // Single sample: strobe at E0+3 only
    sc.delete(); sv.delete();
    b = cyc + 2;
    pulse_at(b, 8'h5A);
    wait_until(b + 2);
    chk("single_level_push", int'(o_fifo_level), 1);
    wait_until(b + 3);
    chk("single_strobe", int'(o_data_strobe), 1);
    chk("single_value",  int'(o_value), 'h5A);
    wait_until(b + 20);
    chk("single_count", sc.size(), 1);
    chk("single_cyc",   gc(0), b + 3);
    chk("single_level_end", int'(o_fifo_level), 0);

    // Burst of three, 4 cycles apart: strobes at E3, E19 and E35
    sc.delete(); sv.delete();
    peak = 0;
    b = cyc + 2;
    pulse_at(b,     8'h01);
    pulse_at(b + 4, 8'h02);
    pulse_at(b + 8, 8'h03);
    wait_until(b + 40);
    chk("burst_count", sc.size(), 3);
    chk("burst_cyc0",  gc(0), b + 3);
    chk("burst_cyc1",  gc(1), b + 19);
    chk("burst_cyc2",  gc(2), b + 35);
    chk("burst_val0",  gv(0), 'h01);
    chk("burst_val1",  gv(1), 'h02);
    chk("burst_val2",  gv(2), 'h03);
    chk("burst_peak",  peak, 2);
    wait_until(b + 56);

    // Fill during GAP, push coinciding with the IDLE pop, then overflow
    sc.delete(); sv.delete();
    c = cyc + 2;
    pulse_at(c,      8'h10);
    pulse_at(c + 3,  8'h11);
    pulse_at(c + 6,  8'h12);
    pulse_at(c + 9,  8'h13);
    pulse_at(c + 12, 8'h14);
    wait_until(c + 14);
    chk("fill_level", int'(o_fifo_level), 4);
    pulse_at(c + 17, 8'h15);            // push lands on the pop at c+19
    wait_until(c + 19);
    chk("fullpop_strobe",   int'(o_data_strobe), 1);
    chk("fullpop_value",    int'(o_value), 'h11);
    chk("fullpop_level",    int'(o_fifo_level), 4);
    chk("fullpop_overflow", int'(o_overflow), 0);
    pulse_at(c + 20, 8'h16);            // push at c+22: full, in GAP -> dropped
    wait_until(c + 22);
    chk("drop_overflow", int'(o_overflow), 1);
    chk("drop_level",    int'(o_fifo_level), 4);
    i_clear_overflow = 1'b1;
    step();
    i_clear_overflow = 1'b0;
    chk("clear_overflow", int'(o_overflow), 0);
    pulse_at(c + 24, 8'h17);            // drop at c+26 together with a clear
    i_clear_overflow = 1'b1;
    step();
    i_clear_overflow = 1'b0;
    chk("set_wins", int'(o_overflow), 1);
    wait_until(c + 35);
    chk("next_strobe", int'(o_data_strobe), 1);
    chk("next_value",  int'(o_value), 'h12);
    chk("next_level",  int'(o_fifo_level), 3);

    // Reset in GAP with level 3, released with the strobe held high
    wait_until(c + 38);
    i_data_clk = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_value",    int'(o_value), 0);
    chk("midrst_strobe",   int'(o_data_strobe), 0);
    chk("midrst_level",    int'(o_fifo_level), 0);
    chk("midrst_overflow", int'(o_overflow), 0);
    repeat (3) step();
    rst = 1'b1;
    sc.delete(); sv.delete();
    r = cyc;
    wait_until(r + 25);
    chk("postrst_no_strobe", sc.size(), 0);
    chk("postrst_level",     int'(o_fifo_level), 0);
    i_data_clk = 1'b0;
    repeat (3) step();

    // Signed extremes, MIN_GAP apart
    sc.delete(); sv.delete();
    b = cyc + 2;
    pulse_at(b,     8'h80);
    pulse_at(b + 4, 8'h7F);
    wait_until(b + 3);
    chk("neg_value", int'(o_value), 'h80);
    wait_until(b + 19);
    chk("pos_strobe", int'(o_data_strobe), 1);
    chk("pos_value",  int'(o_value), 'h7F);
    wait_until(b + 25);
    chk("ext_count",   sc.size(), 2);
    chk("ext_spacing", gc(1) - gc(0), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
